// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer between EX/MEM and the word-addressed data
// memory. Stores are accepted in one cycle and retired to memory in the
// background whenever no load owns the memory port; loads are forwarded from
// the youngest matching pending store.
// Optional feature macro: STORE_BUF_COALESCE_EN (in-place overwrite of the
// youngest entry when a new store targets the same address).
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_hit,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              drain;
  logic              accept;
  logic              enq;
  logic              coal;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

  // Loads always own the port; the head retires only on otherwise idle cycles.
  assign mem_we    = !ld_valid && !empty && !rst;
  assign drain     = mem_we;
  assign mem_addr  = ld_valid ? ld_addr : addr_q[head_q];
  assign mem_wdata = data_q[head_q];

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] young_idx;
  logic             young_match;

  assign young_idx   = tail_q - PTR_W'(1);
  assign young_match = !empty && (addr_q[young_idx] == st_addr);
  // A matching store can merge even when full, so readiness includes the match.
  assign st_ready    = !full || young_match;
  // When the youngest entry is also the head leaving this cycle, merging would
  // lose the data, so that store falls back to a normal allocation.
  assign coal        = st_valid && young_match && !(drain && (count_q == CNT_W'(1)));
`else
  assign st_ready    = !full;
  assign coal        = 1'b0;
`endif

  assign accept = st_valid && st_ready;
  assign enq    = accept && !coal;

  // Forwarding search, oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign ld_hit  = ld_valid && fwd_hit;
  assign ld_data = ld_hit ? fwd_data : mem_rdata;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (enq) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PTR_W'(1);
    end
`ifdef STORE_BUF_COALESCE_EN
    if (coal) begin
      data_d[young_idx] = st_data;
    end
`endif
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
  end

  // Control state with synchronous reset; pending stores are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity is implied by head/count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with a write-order
// scoreboard and a behavioural data memory.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        empty;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem [256];
  wr_t         sb [$];
  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          writes0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_data),
    .ld_hit    (ld_hit),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  function automatic logic [31:0] init_val(input int unsigned i);
    return 32'hA500_0000 | i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Observe any memory write of this cycle, then advance to the next negedge.
  task automatic tick();
    if (mem_we !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'b0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
      end
      mem[mem_addr[7:0]] = mem_wdata;
      writes++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);

    // Reset, with a store presented during reset that must be discarded.
    rst = 1'b1;
    drive(1'b1, 32'h99, 32'h1, 1'b0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_hit", {31'b0, ld_hit}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("rst_discard_empty", {31'b0, empty}, 32'd1);

    // Single store drains on the next idle cycle.
    drive(1'b1, 32'd32, 32'd2, 1'b0, 32'd0);
    chk("t1_ready", {31'b0, st_ready}, 32'd1);
    chk("t1_we_empty", {31'b0, mem_we}, 32'd0);
    push(32'd32, 32'd2);
    tick();
    idle();
    chk("t1_we", {31'b0, mem_we}, 32'd1);
    chk("t1_addr", mem_addr, 32'd32);
    chk("t1_wdata", mem_wdata, 32'd2);
    tick();
    idle();
    chk("t1_empty", {31'b0, empty}, 32'd1);
    chk("t1_count", {29'b0, count}, 32'd0);

    // Fill while loads block the port; full buffer ignores further stores.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(10 + i), 32'(100 + i), 1'b1, 32'd5);
      chk("t2_we_blocked", {31'b0, mem_we}, 32'd0);
      push(32'(10 + i), 32'(100 + i));
      tick();
    end
    drive(1'b1, 32'd14, 32'd114, 1'b1, 32'd5);
    chk("t2_count_full", {29'b0, count}, 32'd4);
    chk("t2_ready_full", {31'b0, st_ready}, 32'd0);
    chk("t2_we_full", {31'b0, mem_we}, 32'd0);
    chk("t2_ld_addr", mem_addr, 32'd5);
    chk("t2_hit_miss", {31'b0, ld_hit}, 32'd0);
    chk("t2_ld_data", ld_data, init_val(5));
    tick();
    drive(1'b1, 32'd14, 32'd114, 1'b0, 32'd0);
    chk("t2_ready_full_drain", {31'b0, st_ready}, 32'd0);
    chk("t2_we_drain", {31'b0, mem_we}, 32'd1);
    tick();
    idle();
    chk("t2_count_after", {29'b0, count}, 32'd3);
    tick();
    tick();
    tick();
    idle();
    chk("t2_empty", {31'b0, empty}, 32'd1);
    chk("t2_no_extra_we", {31'b0, mem_we}, 32'd0);
    tick();

    // Youngest matching entry forwards; non-matching load reads memory.
    drive(1'b1, 32'd40, 32'd7, 1'b1, 32'd99);
`ifndef STORE_BUF_COALESCE_EN
    push(32'd40, 32'd7);
`endif
    tick();
    drive(1'b1, 32'd40, 32'd9, 1'b1, 32'd99);
    push(32'd40, 32'd9);
    tick();
`ifdef STORE_BUF_COALESCE_EN
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd40);
    chk("t3_count", {29'b0, count}, 32'd1);
`else
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd40);
    chk("t3_count", {29'b0, count}, 32'd2);
`endif
    chk("t3_hit", {31'b0, ld_hit}, 32'd1);
    chk("t3_fwd_data", ld_data, 32'd9);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd41);
    chk("t3_miss", {31'b0, ld_hit}, 32'd0);
    chk("t3_miss_data", ld_data, init_val(41));
    chk("t3_miss_addr", mem_addr, 32'd41);
    tick();
    idle();
    tick();
    tick();
    idle();
    chk("t3_empty", {31'b0, empty}, 32'd1);
    chk("t3_mem40", mem[40], 32'd9);

    // Same-cycle store is invisible to the load; visible next cycle.
    drive(1'b1, 32'd50, 32'd3, 1'b1, 32'd50);
    chk("t4_same_hit", {31'b0, ld_hit}, 32'd0);
    chk("t4_same_data", ld_data, init_val(50));
    push(32'd50, 32'd3);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd50);
    chk("t4_next_hit", {31'b0, ld_hit}, 32'd1);
    chk("t4_next_data", ld_data, 32'd3);
    tick();
    idle();
    tick();
    idle();
    chk("t4_empty", {31'b0, empty}, 32'd1);
    chk("t4_mem50", mem[50], 32'd3);

    // Enqueue and drain together at count 1: old head leaves, new entry stays.
    drive(1'b1, 32'd80, 32'd8, 1'b0, 32'd0);
    push(32'd80, 32'd8);
    tick();
    drive(1'b1, 32'd81, 32'd9, 1'b0, 32'd0);
    chk("t5_we", {31'b0, mem_we}, 32'd1);
    chk("t5_ready", {31'b0, st_ready}, 32'd1);
    push(32'd81, 32'd9);
    tick();
    idle();
    chk("t5_count", {29'b0, count}, 32'd1);
    chk("t5_head_addr", mem_addr, 32'd81);
    chk("t5_head_data", mem_wdata, 32'd9);
    tick();
    idle();
    chk("t5_empty", {31'b0, empty}, 32'd1);

    // Reset with pending stores discards them without touching memory.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(70 + i), 32'(1 + i), 1'b1, 32'd0);
      tick();
    end
    idle();
    chk("t6_count3", {29'b0, count}, 32'd3);
    rst = 1'b1;
    drive(1'b1, 32'd73, 32'd4, 1'b0, 32'd0);
    chk("t6_rst_we", {31'b0, mem_we}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("t6_count0", {29'b0, count}, 32'd0);
    chk("t6_empty", {31'b0, empty}, 32'd1);
    chk("t6_we_after", {31'b0, mem_we}, 32'd0);
    tick();
    tick();
    chk("t6_mem70", mem[70], init_val(70));
    chk("t6_mem72", mem[72], init_val(72));

    // Repeated address to the youngest entry while the port is blocked.
    writes0 = writes;
    drive(1'b1, 32'd60, 32'd1, 1'b1, 32'd0);
`ifndef STORE_BUF_COALESCE_EN
    push(32'd60, 32'd1);
`endif
    tick();
    drive(1'b1, 32'd60, 32'd5, 1'b1, 32'd0);
    push(32'd60, 32'd5);
    tick();
    idle();
`ifdef STORE_BUF_COALESCE_EN
    chk("t7_count", {29'b0, count}, 32'd1);
`else
    chk("t7_count", {29'b0, count}, 32'd2);
`endif
    tick();
    tick();
    idle();
`ifdef STORE_BUF_COALESCE_EN
    chk("t7_writes", 32'(writes - writes0), 32'd1);
`else
    chk("t7_writes", 32'(writes - writes0), 32'd2);
`endif
    chk("t7_mem60", mem[60], 32'd5);
    chk("t7_empty", {31'b0, empty}, 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
